// File: rtl/dmi_arbiter.sv
// Two-requester round-robin DMI arbiter; one outstanding DM transaction; NOP/reserved answered locally.
// Latency: accept t -> DM req t+1 -> rsp t+3 (zero-wait DM); local ops rsp t+1. Optional DMI_ARB_TIMEOUT_EN.
// Backpressure: requesters see ready only in IDLE for the granted side; DM request held until dmi_req_ready_i.
module dmi_arbiter #(
    parameter int ADDR_W         = 7,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req_valid_i,
    output logic              m0_req_ready_o,
    input  logic [1:0]        m0_req_op_i,
    input  logic [ADDR_W-1:0] m0_req_address_i,
    input  logic [DATA_W-1:0] m0_req_data_i,
    output logic              m0_rsp_valid_o,
    output logic [1:0]        m0_rsp_op_o,
    output logic [DATA_W-1:0] m0_rsp_data_o,
    input  logic              m1_req_valid_i,
    output logic              m1_req_ready_o,
    input  logic [1:0]        m1_req_op_i,
    input  logic [ADDR_W-1:0] m1_req_address_i,
    input  logic [DATA_W-1:0] m1_req_data_i,
    output logic              m1_rsp_valid_o,
    output logic [1:0]        m1_rsp_op_o,
    output logic [DATA_W-1:0] m1_rsp_data_o,
    output logic              dmi_req_valid_o,
    input  logic              dmi_req_ready_i,
    output logic [1:0]        dmi_req_op_o,
    output logic [ADDR_W-1:0] dmi_req_address_o,
    output logic [DATA_W-1:0] dmi_req_data_o,
    input  logic              dmi_rsp_valid_i,
    input  logic [1:0]        dmi_rsp_op_i,
    input  logic [DATA_W-1:0] dmi_rsp_data_i
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_last_m1;
    logic                r_owner_m1;
    logic [1:0]          r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_rsp_op;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                w_gnt_m0;
    logic                w_gnt_m1;
    logic                w_accept;
    logic [1:0]          w_req_op;
    logic [ADDR_W-1:0]   w_req_addr;
    logic [DATA_W-1:0]   w_req_data;
    logic                w_timeout;

    // Reset starts with "last granted = m1" so m0 wins the first contested grant.
    assign w_gnt_m0   = m0_req_valid_i && (!m1_req_valid_i || r_last_m1);
    assign w_gnt_m1   = m1_req_valid_i && !w_gnt_m0;
    assign w_accept   = (r_state == S_IDLE) && !reset && (w_gnt_m0 || w_gnt_m1);
    assign w_req_op   = w_gnt_m1 ? m1_req_op_i      : m0_req_op_i;
    assign w_req_addr = w_gnt_m1 ? m1_req_address_i : m0_req_address_i;
    assign w_req_data = w_gnt_m1 ? m1_req_data_i    : m0_req_data_i;

`ifdef DMI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_wait_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_state == S_WAIT) && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next            = r_state;
        m0_req_ready_o    = 1'b0;
        m1_req_ready_o    = 1'b0;
        dmi_req_valid_o   = 1'b0;
        dmi_req_op_o      = '0;
        dmi_req_address_o = '0;
        dmi_req_data_o    = '0;
        m0_rsp_valid_o    = 1'b0;
        m0_rsp_op_o       = '0;
        m0_rsp_data_o     = '0;
        m1_rsp_valid_o    = 1'b0;
        m1_rsp_op_o       = '0;
        m1_rsp_data_o     = '0;
        case (r_state)
            S_IDLE: begin
                m0_req_ready_o = !reset && w_gnt_m0;
                m1_req_ready_o = !reset && w_gnt_m1;
                if (w_accept) begin
                    w_next = (w_req_op == 2'b01 || w_req_op == 2'b10) ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: begin
                dmi_req_valid_o   = 1'b1;
                dmi_req_op_o      = r_op;
                dmi_req_address_o = r_addr;
                dmi_req_data_o    = r_data;
                if (dmi_req_ready_i) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dmi_rsp_valid_i || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                m0_rsp_valid_o = !r_owner_m1;
                m0_rsp_op_o    = r_owner_m1 ? 2'b00 : r_rsp_op;
                m0_rsp_data_o  = r_owner_m1 ? '0 : r_rsp_data;
                m1_rsp_valid_o = r_owner_m1;
                m1_rsp_op_o    = r_owner_m1 ? r_rsp_op : 2'b00;
                m1_rsp_data_o  = r_owner_m1 ? r_rsp_data : '0;
                w_next         = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Local ops preload their final response at accept; DM ops overwrite it in WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_m1  <= 1'b1;
            r_owner_m1 <= 1'b0;
            r_op       <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_rsp_op   <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_op       <= w_req_op;
                r_addr     <= w_req_addr;
                r_data     <= w_req_data;
                r_owner_m1 <= w_gnt_m1;
                r_last_m1  <= w_gnt_m1;
                r_rsp_op   <= (w_req_op == 2'b11) ? 2'b10 : 2'b00;
                r_rsp_data <= '0;
            end
            if (r_state == S_WAIT) begin
                if (dmi_rsp_valid_i) begin
                    r_rsp_op   <= dmi_rsp_op_i;
                    r_rsp_data <= dmi_rsp_data_i;
                end else if (w_timeout) begin
                    r_rsp_op   <= 2'b11;
                    r_rsp_data <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed bench for dmi_arbiter; timeout scenario is built only with DMI_ARB_TIMEOUT_EN.
module tb_dmi_arbiter;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              m0_req_valid_i = 0, m1_req_valid_i = 0;
    logic              m0_req_ready_o, m1_req_ready_o;
    logic [1:0]        m0_req_op_i = 0, m1_req_op_i = 0;
    logic [ADDR_W-1:0] m0_req_address_i = 0, m1_req_address_i = 0;
    logic [DATA_W-1:0] m0_req_data_i = 0, m1_req_data_i = 0;
    logic              m0_rsp_valid_o, m1_rsp_valid_o;
    logic [1:0]        m0_rsp_op_o, m1_rsp_op_o;
    logic [DATA_W-1:0] m0_rsp_data_o, m1_rsp_data_o;
    logic              dmi_req_valid_o;
    logic              dmi_req_ready_i = 0;
    logic [1:0]        dmi_req_op_o;
    logic [ADDR_W-1:0] dmi_req_address_o;
    logic [DATA_W-1:0] dmi_req_data_o;
    logic              dmi_rsp_valid_i = 0;
    logic [1:0]        dmi_rsp_op_i = 0;
    logic [DATA_W-1:0] dmi_rsp_data_i = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .m0_req_valid_i(m0_req_valid_i), .m0_req_ready_o(m0_req_ready_o),
        .m0_req_op_i(m0_req_op_i), .m0_req_address_i(m0_req_address_i), .m0_req_data_i(m0_req_data_i),
        .m0_rsp_valid_o(m0_rsp_valid_o), .m0_rsp_op_o(m0_rsp_op_o), .m0_rsp_data_o(m0_rsp_data_o),
        .m1_req_valid_i(m1_req_valid_i), .m1_req_ready_o(m1_req_ready_o),
        .m1_req_op_i(m1_req_op_i), .m1_req_address_i(m1_req_address_i), .m1_req_data_i(m1_req_data_i),
        .m1_rsp_valid_o(m1_rsp_valid_o), .m1_rsp_op_o(m1_rsp_op_o), .m1_rsp_data_o(m1_rsp_data_o),
        .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
        .dmi_req_op_o(dmi_req_op_o), .dmi_req_address_o(dmi_req_address_o), .dmi_req_data_o(dmi_req_data_o),
        .dmi_rsp_valid_i(dmi_rsp_valid_i), .dmi_rsp_op_i(dmi_rsp_op_i), .dmi_rsp_data_i(dmi_rsp_data_i)
    );

    // Idle response ports must be all-zero and the two responses must never overlap.
    always @(negedge clk) begin
        checks++;
        if ((!m0_rsp_valid_o && (m0_rsp_op_o !== 2'b00 || m0_rsp_data_o !== 32'h0)) ||
            (!m1_rsp_valid_o && (m1_rsp_op_o !== 2'b00 || m1_rsp_data_o !== 32'h0)) ||
            (m0_rsp_valid_o && m1_rsp_valid_o)) begin
            errors++;
            $display("FAIL rsp_idle_zero at %0t: m0 %b/%h/%h m1 %b/%h/%h, required idle ports zero and no overlap",
                     $time, m0_rsp_valid_o, m0_rsp_op_o, m0_rsp_data_o, m1_rsp_valid_o, m1_rsp_op_o, m1_rsp_data_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        m0_req_valid_i = 1'b1; m0_req_op_i = 2'b01;
        tick(); tick(); #1;
        checks++; if (m0_req_ready_o !== 1'b0) begin errors++; $display("FAIL reset_m0_ready: got %b want 0", m0_req_ready_o); end
        checks++; if (m1_req_ready_o !== 1'b0) begin errors++; $display("FAIL reset_m1_ready: got %b want 0", m1_req_ready_o); end
        checks++; if ({dmi_req_valid_o, dmi_req_op_o, dmi_req_address_o, dmi_req_data_o} !== '0) begin
            errors++; $display("FAIL reset_dmi_req: got %b/%h/%h/%h want all 0", dmi_req_valid_o, dmi_req_op_o, dmi_req_address_o, dmi_req_data_o); end
        checks++; if ({m0_rsp_valid_o, m1_rsp_valid_o} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", {m0_rsp_valid_o, m1_rsp_valid_o}); end
        m0_req_valid_i = 1'b0; m0_req_op_i = 2'b00;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_write;
        tick();
        m0_req_valid_i = 1'b1; m0_req_op_i = 2'b10; m0_req_address_i = 7'h04; m0_req_data_i = 32'h24;
        dmi_req_ready_i = 1'b1; #1;
        checks++; if ({m0_req_ready_o, m1_req_ready_o} !== 2'b10) begin errors++; $display("FAIL wr_ready: got %b want 10", {m0_req_ready_o, m1_req_ready_o}); end
        tick(); m0_req_valid_i = 1'b0; #1;
        checks++; if ({dmi_req_valid_o, dmi_req_op_o, dmi_req_address_o, dmi_req_data_o} !== {1'b1, 2'b10, 7'h04, 32'h24}) begin
            errors++; $display("FAIL wr_dmi_req: got %b/%h/%h/%h want 1/2/04/00000024", dmi_req_valid_o, dmi_req_op_o, dmi_req_address_o, dmi_req_data_o); end
        tick(); dmi_rsp_valid_i = 1'b1; dmi_rsp_op_i = 2'b00; dmi_rsp_data_i = 32'h0; #1;
        checks++; if ({dmi_req_valid_o, m0_rsp_valid_o} !== 2'b00) begin errors++; $display("FAIL wr_wait: req/rsp got %b want 00", {dmi_req_valid_o, m0_rsp_valid_o}); end
        tick(); dmi_rsp_valid_i = 1'b0; #1;
        checks++; if ({m0_rsp_valid_o, m0_rsp_op_o, m0_rsp_data_o} !== {1'b1, 2'b00, 32'h0}) begin
            errors++; $display("FAIL wr_m0_rsp: got %b/%h/%h want 1/0/0", m0_rsp_valid_o, m0_rsp_op_o, m0_rsp_data_o); end
        checks++; if (m1_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL wr_m1_quiet: got %b want 0", m1_rsp_valid_o); end
        tick(); #1;
        checks++; if (m0_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL wr_rsp_single: got %b want 0", m0_rsp_valid_o); end
    endtask

    task automatic test_round_robin;
        tick(); reset = 1'b1; tick(); reset = 1'b0;
        m0_req_valid_i = 1'b1; m0_req_op_i = 2'b01; m0_req_address_i = 7'h11; m0_req_data_i = 32'h0;
        m1_req_valid_i = 1'b1; m1_req_op_i = 2'b01; m1_req_address_i = 7'h11; m1_req_data_i = 32'h0;
        dmi_req_ready_i = 1'b1; #1;
        checks++; if ({m0_req_ready_o, m1_req_ready_o} !== 2'b10) begin errors++; $display("FAIL rr_first_grant: got %b want 10", {m0_req_ready_o, m1_req_ready_o}); end
        tick(); m0_req_valid_i = 1'b0; #1;
        checks++; if ({dmi_req_valid_o, dmi_req_op_o, dmi_req_address_o, m1_req_ready_o} !== {1'b1, 2'b01, 7'h11, 1'b0}) begin
            errors++; $display("FAIL rr_m0_issue: got %b/%h/%h ready1=%b want 1/1/11 ready1=0", dmi_req_valid_o, dmi_req_op_o, dmi_req_address_o, m1_req_ready_o); end
        tick(); dmi_rsp_valid_i = 1'b1; dmi_rsp_op_i = 2'b00; dmi_rsp_data_i = 32'h101;
        tick(); dmi_rsp_valid_i = 1'b0; m0_req_valid_i = 1'b1; #1;
        checks++; if ({m0_rsp_valid_o, m0_rsp_op_o, m0_rsp_data_o} !== {1'b1, 2'b00, 32'h101}) begin
            errors++; $display("FAIL rr_m0_rsp: got %b/%h/%h want 1/0/00000101", m0_rsp_valid_o, m0_rsp_op_o, m0_rsp_data_o); end
        checks++; if ({m0_req_ready_o, m1_req_ready_o} !== 2'b00) begin errors++; $display("FAIL rr_no_accept_in_resp: got %b want 00", {m0_req_ready_o, m1_req_ready_o}); end
        tick(); #1;
        checks++; if ({m0_req_ready_o, m1_req_ready_o} !== 2'b01) begin errors++; $display("FAIL rr_second_grant: got %b want 01", {m0_req_ready_o, m1_req_ready_o}); end
        tick(); m0_req_valid_i = 1'b0; m1_req_valid_i = 1'b0; #1;
        checks++; if (dmi_req_valid_o !== 1'b1) begin errors++; $display("FAIL rr_m1_issue: got %b want 1", dmi_req_valid_o); end
        tick(); dmi_rsp_valid_i = 1'b1; dmi_rsp_data_i = 32'h303;
        tick(); dmi_rsp_valid_i = 1'b0; #1;
        checks++; if ({m1_rsp_valid_o, m1_rsp_op_o, m1_rsp_data_o, m0_rsp_valid_o} !== {1'b1, 2'b00, 32'h303, 1'b0}) begin
            errors++; $display("FAIL rr_m1_rsp: got %b/%h/%h m0v=%b want 1/0/00000303 m0v=0", m1_rsp_valid_o, m1_rsp_op_o, m1_rsp_data_o, m0_rsp_valid_o); end
        tick();
    endtask

    task automatic test_stall;
        int stable_cnt;
        stable_cnt = 0;
        m1_req_valid_i = 1'b1; m1_req_op_i = 2'b10; m1_req_address_i = 7'h10; m1_req_data_i = 32'h80000001;
        dmi_req_ready_i = 1'b0; #1;
        checks++; if (m1_req_ready_o !== 1'b1) begin errors++; $display("FAIL stall_grant: got %b want 1", m1_req_ready_o); end
        tick(); m1_req_valid_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            dmi_req_ready_i = (i == 5); #1;
            if ({dmi_req_valid_o, dmi_req_op_o, dmi_req_address_o, dmi_req_data_o} === {1'b1, 2'b10, 7'h10, 32'h80000001})
                stable_cnt++;
            tick();
        end
        checks++; if (stable_cnt !== 6) begin errors++; $display("FAIL stall_hold: stable cycles got %0d want 6", stable_cnt); end
        #1;
        checks++; if (dmi_req_valid_o !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", dmi_req_valid_o); end
        dmi_rsp_valid_i = 1'b1; dmi_rsp_op_i = 2'b00; dmi_rsp_data_i = 32'h0;
        tick(); dmi_rsp_valid_i = 1'b0; #1;
        checks++; if ({m1_rsp_valid_o, m1_rsp_op_o, m0_rsp_valid_o} !== 4'b1000) begin
            errors++; $display("FAIL stall_m1_rsp: got m1 %b/%h m0v %b want 1/0 m0v 0", m1_rsp_valid_o, m1_rsp_op_o, m0_rsp_valid_o); end
        tick(); #1;
        checks++; if (m1_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL stall_rsp_single: got %b want 0", m1_rsp_valid_o); end
    endtask

    task automatic test_local_ops;
        m0_req_valid_i = 1'b1; m0_req_op_i = 2'b00; m0_req_address_i = 7'h05; m0_req_data_i = 32'hDEAD;
        dmi_req_ready_i = 1'b1; #1;
        checks++; if (m0_req_ready_o !== 1'b1) begin errors++; $display("FAIL nop_grant: got %b want 1", m0_req_ready_o); end
        tick(); m0_req_valid_i = 1'b0;
        m1_req_valid_i = 1'b1; m1_req_op_i = 2'b11; m1_req_address_i = 7'h03; m1_req_data_i = 32'h77; #1;
        checks++; if ({m0_rsp_valid_o, m0_rsp_op_o, m0_rsp_data_o, dmi_req_valid_o, m1_req_ready_o} !== {1'b1, 2'b00, 32'h0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL nop_rsp: got %b/%h/%h dmi=%b rdy1=%b want 1/0/0 dmi=0 rdy1=0", m0_rsp_valid_o, m0_rsp_op_o, m0_rsp_data_o, dmi_req_valid_o, m1_req_ready_o); end
        tick(); #1;
        checks++; if ({m1_req_ready_o, dmi_req_valid_o} !== 2'b10) begin errors++; $display("FAIL rsvd_grant: got %b want 10", {m1_req_ready_o, dmi_req_valid_o}); end
        tick(); m1_req_valid_i = 1'b0; #1;
        checks++; if ({m1_rsp_valid_o, m1_rsp_op_o, m1_rsp_data_o, dmi_req_valid_o} !== {1'b1, 2'b10, 32'h0, 1'b0}) begin
            errors++; $display("FAIL rsvd_rsp: got %b/%h/%h dmi=%b want 1/2/0 dmi=0", m1_rsp_valid_o, m1_rsp_op_o, m1_rsp_data_o, dmi_req_valid_o); end
        tick();
    endtask

    task automatic test_issue_rsp_ignored;
        m0_req_valid_i = 1'b1; m0_req_op_i = 2'b01; m0_req_address_i = 7'h22; dmi_req_ready_i = 1'b1;
        tick(); m0_req_valid_i = 1'b0;
        dmi_rsp_valid_i = 1'b1; dmi_rsp_op_i = 2'b10; dmi_rsp_data_i = 32'h999; #1;
        checks++; if (dmi_req_valid_o !== 1'b1) begin errors++; $display("FAIL early_issue: got %b want 1", dmi_req_valid_o); end
        tick(); dmi_rsp_valid_i = 1'b0; #1;
        checks++; if (m0_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL early_rsp_dropped: got %b want 0", m0_rsp_valid_o); end
        dmi_rsp_valid_i = 1'b1; dmi_rsp_op_i = 2'b00; dmi_rsp_data_i = 32'h42;
        tick(); dmi_rsp_valid_i = 1'b0; #1;
        checks++; if ({m0_rsp_valid_o, m0_rsp_op_o, m0_rsp_data_o} !== {1'b1, 2'b00, 32'h42}) begin
            errors++; $display("FAIL early_real_rsp: got %b/%h/%h want 1/0/00000042", m0_rsp_valid_o, m0_rsp_op_o, m0_rsp_data_o); end
        tick();
    endtask

    task automatic test_reset_mid;
        m0_req_valid_i = 1'b1; m0_req_op_i = 2'b01; m0_req_address_i = 7'h33; dmi_req_ready_i = 1'b1;
        tick(); m0_req_valid_i = 1'b0;
        tick(); reset = 1'b1; #1;
        checks++; if ({dmi_req_valid_o, m0_req_ready_o, m1_req_ready_o, m0_rsp_valid_o, m1_rsp_valid_o} !== 5'b0) begin
            errors++; $display("FAIL midrst_outputs: got %b want 00000", {dmi_req_valid_o, m0_req_ready_o, m1_req_ready_o, m0_rsp_valid_o, m1_rsp_valid_o}); end
        tick(); reset = 1'b0;
        tick(); tick();
        dmi_rsp_valid_i = 1'b1; dmi_rsp_op_i = 2'b00; dmi_rsp_data_i = 32'h555;
        tick(); dmi_rsp_valid_i = 1'b0; #1;
        checks++; if ({m0_rsp_valid_o, m1_rsp_valid_o} !== 2'b00) begin errors++; $display("FAIL midrst_stale_rsp: got %b want 00", {m0_rsp_valid_o, m1_rsp_valid_o}); end
        m0_req_valid_i = 1'b1; m0_req_op_i = 2'b10; m0_req_address_i = 7'h04; m0_req_data_i = 32'h1234; #1;
        checks++; if (m0_req_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_regrant: got %b want 1", m0_req_ready_o); end
        tick(); m0_req_valid_i = 1'b0; #1;
        checks++; if ({dmi_req_valid_o, dmi_req_op_o, dmi_req_address_o, dmi_req_data_o} !== {1'b1, 2'b10, 7'h04, 32'h1234}) begin
            errors++; $display("FAIL midrst_issue: got %b/%h/%h/%h want 1/2/04/00001234", dmi_req_valid_o, dmi_req_op_o, dmi_req_address_o, dmi_req_data_o); end
        tick(); dmi_rsp_valid_i = 1'b1; dmi_rsp_data_i = 32'h0;
        tick(); dmi_rsp_valid_i = 1'b0; #1;
        checks++; if ({m0_rsp_valid_o, m0_rsp_op_o} !== 3'b100) begin errors++; $display("FAIL midrst_rsp: got %b/%h want 1/0", m0_rsp_valid_o, m0_rsp_op_o); end
        tick();
    endtask

`ifdef DMI_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int early;
        early = 0;
        m0_req_valid_i = 1'b1; m0_req_op_i = 2'b01; m0_req_address_i = 7'h01; dmi_req_ready_i = 1'b1;
        tick(); m0_req_valid_i = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            #1;
            if (m0_rsp_valid_o !== 1'b0) early++;
            tick();
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL to_early: responses before timeout got %0d want 0", early); end
        #1;
        checks++; if ({m0_rsp_valid_o, m0_rsp_op_o, m0_rsp_data_o} !== {1'b1, 2'b11, 32'h0}) begin
            errors++; $display("FAIL to_busy: got %b/%h/%h want 1/3/0", m0_rsp_valid_o, m0_rsp_op_o, m0_rsp_data_o); end
        tick(); dmi_rsp_valid_i = 1'b1; dmi_rsp_data_i = 32'hABC;
        tick(); dmi_rsp_valid_i = 1'b0; #1;
        checks++; if ({m0_rsp_valid_o, dmi_req_valid_o} !== 2'b00) begin errors++; $display("FAIL to_late_rsp: got %b want 00", {m0_rsp_valid_o, dmi_req_valid_o}); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_round_robin();
        test_stall();
        test_local_ops();
        test_issue_rsp_ignored();
        test_reset_mid();
`ifdef DMI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
